// File: rtl/ascii_dec_parser_if.sv
// rtl/ascii_dec_parser_if.sv - handshake bundle between a character source/value sink and ascii_dec_parser
//
// Purpose: groups the character input stream, the parsed-value output stream
// and the error pulses of ascii_dec_parser into one interface.
//
// Signals:
//   in_valid/in_ready/in_data      9-bit {RS, ASCII} word stream into the parser
//   out_valid/out_ready            parsed-number handshake out of the parser
//   out_value/out_digits           parsed value and its digit count
//   err_overflow/err_char          one-cycle error pulses
//   out_neg                        sign of the parsed number (ASCII_DEC_PARSER_SIGN_EN only)
//
// Modports:
//   master  character source + value sink side
//   slave   the parser itself
//
// Optional feature macro: ASCII_DEC_PARSER_SIGN_EN

interface ascii_dec_parser_if #(
  parameter int VAL_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [VAL_W-1:0] out_value;
  logic [2:0]       out_digits;
  logic             err_overflow;
  logic             err_char;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  logic             out_neg;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_value, out_digits, err_overflow, err_char, out_neg
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_value, out_digits, err_overflow, err_char, out_neg
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_value, out_digits, err_overflow, err_char
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_value, out_digits, err_overflow, err_char
  );
`endif
endinterface

// File: rtl/ascii_dec_parser.sv
// rtl/ascii_dec_parser.sv - decimal ASCII digit stream to binary value parser
//
// Purpose: accumulates RS=1 decimal digit characters into a binary value and
// presents it on a valid/ready output when a terminator (CR, LF or space)
// arrives. RS=0 command words are consumed and ignored. Illegal characters
// and values beyond MAX_VAL / MAX_DIGITS raise one-cycle error pulses and the
// rest of the field is discarded up to the next terminator.
//
// Ports:
//   clk_50   system clock
//   reset    synchronous, active-high reset
//   bus      ascii_dec_parser_if.slave: in_valid/in_ready/in_data,
//            out_valid/out_ready/out_value/out_digits, err_overflow, err_char
//            (and out_neg with ASCII_DEC_PARSER_SIGN_EN)
//
// Optional feature macro: ASCII_DEC_PARSER_SIGN_EN
//   A leading '-' marks the number negative; out_neg reports it in HOLD.

module ascii_dec_parser #(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 12,
  parameter int MAX_VAL    = 4095
) (
  input  logic               clk_50,
  input  logic               reset,
  ascii_dec_parser_if.slave  bus
);

  // acc*10 + 9 needs four extra bits for the multiply and one for the add
  localparam int NW = VAL_W + 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DISCARD,
    HOLD
  } state_t;

  state_t           state, state_nx;
  logic [VAL_W-1:0] acc, acc_nx;
  logic [2:0]       cnt, cnt_nx;
  logic [VAL_W-1:0] val_q, val_nx;
  logic [2:0]       dig_q, dig_nx;
  logic             ov_q, ov_nx;
  logic             ch_q, ch_nx;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  logic             neg_q, neg_nx;
  logic             is_minus;
`endif

  logic             fire;
  logic             rs;
  logic [7:0]       ch;
  logic             is_digit;
  logic             is_term;
  logic [NW-1:0]    nxt;

  assign fire     = bus.in_valid && bus.in_ready;
  assign rs       = bus.in_data[8];
  assign ch       = bus.in_data[7:0];
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_term  = (ch == 8'h0D) || (ch == 8'h0A) || (ch == 8'h20);
  assign nxt      = NW'(acc) * NW'(10) + NW'(ch[3:0]);
`ifdef ASCII_DEC_PARSER_SIGN_EN
  assign is_minus = (ch == 8'h2D);
`endif

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      val_q <= '0;
      dig_q <= '0;
      ov_q  <= 1'b0;
      ch_q  <= 1'b0;
`ifdef ASCII_DEC_PARSER_SIGN_EN
      neg_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      val_q <= val_nx;
      dig_q <= dig_nx;
      ov_q  <= ov_nx;
      ch_q  <= ch_nx;
`ifdef ASCII_DEC_PARSER_SIGN_EN
      neg_q <= neg_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    val_nx   = val_q;
    dig_nx   = dig_q;
    ov_nx    = 1'b0;
    ch_nx    = 1'b0;
`ifdef ASCII_DEC_PARSER_SIGN_EN
    neg_nx   = neg_q;
`endif

    case (state)
      IDLE: begin
        if (fire && rs) begin
          if (is_digit) begin
            state_nx = ACCUM;
            acc_nx   = VAL_W'(ch[3:0]);
            cnt_nx   = 3'd1;
          end else if (is_term) begin
            // empty field: nothing to report
            state_nx = IDLE;
`ifdef ASCII_DEC_PARSER_SIGN_EN
          end else if (is_minus) begin
            state_nx = ACCUM;
            neg_nx   = 1'b1;
            acc_nx   = '0;
            cnt_nx   = 3'd0;
`endif
          end else begin
            ch_nx    = 1'b1;
            state_nx = DISCARD;
          end
        end
      end

      ACCUM: begin
        if (fire && rs) begin
          if (is_digit) begin
            // digit budget is checked before the value so "00042" overflows
            if ((cnt == 3'(MAX_DIGITS)) || (nxt > NW'(MAX_VAL))) begin
              ov_nx    = 1'b1;
              state_nx = DISCARD;
            end else begin
              acc_nx = nxt[VAL_W-1:0];
              cnt_nx = cnt + 3'd1;
            end
          end else if (is_term) begin
`ifdef ASCII_DEC_PARSER_SIGN_EN
            if (cnt == 3'd0) begin
              // a lone '-' carries no magnitude
              ch_nx    = 1'b1;
              state_nx = IDLE;
              acc_nx   = '0;
              neg_nx   = 1'b0;
            end else begin
              state_nx = HOLD;
              val_nx   = acc;
              dig_nx   = cnt;
            end
`else
            state_nx = HOLD;
            val_nx   = acc;
            dig_nx   = cnt;
`endif
          end else begin
            ch_nx    = 1'b1;
            state_nx = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (fire && rs && is_term) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = 3'd0;
`ifdef ASCII_DEC_PARSER_SIGN_EN
          neg_nx   = 1'b0;
`endif
        end
      end

      HOLD: begin
        // out_valid is implied by HOLD, so only out_ready gates the release
        if (bus.out_ready) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = 3'd0;
`ifdef ASCII_DEC_PARSER_SIGN_EN
          neg_nx   = 1'b0;
`endif
        end
      end

      default: begin
        state_nx = IDLE;
        acc_nx   = '0;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  assign bus.in_ready     = (state != HOLD);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_value    = val_q;
  assign bus.out_digits   = dig_q;
  assign bus.err_overflow = ov_q;
  assign bus.err_char     = ch_q;
`ifdef ASCII_DEC_PARSER_SIGN_EN
  assign bus.out_neg      = neg_q && (state == HOLD);
`endif

endmodule

// File: doc/ascii_dec_parser.md
Name: ascii_dec_parser

Overview:
- Reverse direction of the binary-to-ASCII digit path that feeds the LCD.
- Accepts a byte stream of 9-bit {RS, ASCII} words, one per handshake, from the UART receive path or an LCD-format character source.
- Accumulates decimal digit characters into a binary value.
- Presents the value on a valid/ready output when a terminator arrives. Typical sinks are ADC threshold and PWM set-point registers.

Parameters:
- MAX_DIGITS, 4, maximum digit characters accepted per number.
- VAL_W, 12, width of out_value.
- MAX_VAL, 4095, largest legal value; larger values raise an overflow error.

Ports:
- clk_50  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  parser can accept in_data this cycle.
- in_data  input  9  {RS, ASCII}: bit 8 = RS, bits 7:0 = character.
- out_valid  output  1  parsed number is available.
- out_ready  input  1  consumer takes the number.
- out_value  output  VAL_W  parsed binary value.
- out_digits  output  3  number of digits in out_value.
- err_overflow  output  1  one-cycle pulse when an overflow is detected.
- err_char  output  1  one-cycle pulse when an illegal character is detected.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, accumulator = 0, digit count = 0.
  - in_ready = 1, out_valid = 0, out_value = 0, out_digits = 0.
  - err_overflow = 0, err_char = 0.
- Reset asserted mid-number, or while in HOLD: the pending value is dropped with no output.
- Input handshake: a word is consumed when in_valid && in_ready. in_ready = 1 in IDLE, ACCUM and DISCARD; 0 in HOLD.
- Word classification (only when RS = 1):
  - digit: 0x30–0x39.
  - terminator: 0x0D, 0x0A or 0x20.
  - anything else is illegal.
- Words with RS = 0 are command bytes. They are consumed and ignored in every state, with no state change.
- States:
  - IDLE:
    - digit → ACCUM; acc = d, count = 1.
    - terminator → stay in IDLE, no output (empty field).
    - illegal → err_char pulse, go to DISCARD.
  - ACCUM:
    - digit → next = acc*10 + d, computed 17 bits wide.
    - If count == MAX_DIGITS or next > MAX_VAL: err_overflow pulse, go to DISCARD.
    - Otherwise acc = next, count += 1.
    - terminator → HOLD; out_value = acc[VAL_W-1:0], out_digits = count, out_valid = 1.
    - illegal → err_char pulse, go to DISCARD.
  - DISCARD:
    - Consume words until a terminator, then go to IDLE with acc = 0, count = 0. No output.
  - HOLD:
    - out_valid stays high; out_value and out_digits stay stable.
    - When out_valid && out_ready: go to IDLE, out_valid = 0, acc = 0, count = 0.
- Latency:
  - Terminator accepted on cycle N → out_valid high on N+1.
  - Error detected on an accepting edge → the error pulse is high the following cycle only.
- Leading zeros count as digits: "0042" gives 42 with out_digits = 4; "00042" overflows.
- Value exactly MAX_VAL is legal; MAX_VAL+1 overflows.
- Error pulses never coincide with out_valid rising.

Optional Feature:
- Macro: ASCII_DEC_PARSER_SIGN_EN.
- When defined:
  - Extra output out_neg (1 bit), reset 0.
  - '-' (0x2D, RS = 1) in IDLE sets a neg flag and moves to ACCUM with count = 0.
  - A terminator in ACCUM with count == 0 (lone "-") → err_char pulse, go to IDLE.
  - out_neg = neg flag while in HOLD. The magnitude limit is unchanged.
- When undefined: '-' is an illegal character, and the out_neg port does not exist.

Test Plan:
- After reset, send {1,"1"},{1,"2"},{1,"3"},{1,0x0D} with out_ready = 1 → one-cycle out_valid, out_value = 123, out_digits = 3, no error pulses.
- Send "4095" then CR, with out_ready held 0 for 5 cycles → out_valid stays high with value 4095; in_ready = 0 in HOLD; out_valid falls on the cycle after out_ready rises.
- Send "4096" then CR → err_overflow pulses once after the '6'; no out_valid. A following "7" CR yields out_value = 7.
- Send {1,"1"},{0,0x80},{1,"2"},{1,"A"},{1,"5"}, then {1,0x20} → the RS = 0 word is ignored and err_char pulses once on 'A'; no output. A following "12" plus 0x0A yields 12.
- Send "98", then assert reset for 1 cycle, then "5" CR → out_value = 5, out_digits = 1. A lone CR or 0x20 from IDLE produces no output and no error.
- With ASCII_DEC_PARSER_SIGN_EN defined: "-250" CR → out_neg = 1, out_value = 250. "-" CR → err_char pulse, no out_valid.
